instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter: takes the current `PC`, fetches the 32-bit instruction word over a request/grant/response instruction-memory bus, and presents it to decode with a one-cycle valid strobe. It also drives `FetchStall` back to the PC register so the PC advances only when an instruction has actually been delivered. Fetch errors, misaligned PCs and bus timeouts raise a sticky fault.

---
 rtl/instr_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: req/gnt/rsp bus master with sticky fault.
// Optional last-hit buffer enabled by defining IFETCH_LASTHIT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        FetchEn,
  input  logic        Flush,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        FetchStall,
  output logic        FetchFault,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic [31:0] IMemRData,
  input  logic        IMemRValid,
  input  logic        IMemErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_nx;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [7:0]  cnt_q;
  logic        discard_q;

  logic        aligned;
  logic        drop;
  logic        timeout;
  logic        rsp;
  logic        rsp_ok;
  logic        hit;

  assign aligned = (PC[1:0] == 2'b00);
  assign drop    = discard_q | Flush;
  assign timeout = ((cnt_q + 8'd1) == TO);
  assign rsp     = (state == S_WAIT) & IMemRValid;
  assign rsp_ok  = rsp & ~IMemErr & ~drop;

`ifdef IFETCH_LASTHIT_EN
  logic        buf_v;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;

  assign hit = buf_v & (buf_addr == PC);

  // last successful fetch; any bus error invalidates it
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      buf_v    <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (rsp & IMemErr) begin
      buf_v    <= 1'b0;
    end else if (rsp_ok) begin
      buf_v    <= 1'b1;
      buf_addr <= addr_q;
      buf_data <= IMemRData;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (FetchEn) begin
          if (!aligned) state_nx = S_FAULT;
          else if (hit) state_nx = S_DONE;
          else          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (IMemGnt) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (IMemRValid) begin
          if (drop)         state_nx = S_IDLE;
          else if (IMemErr) state_nx = S_FAULT;
          else              state_nx = S_DONE;
        end else if (timeout) begin
          state_nx = S_FAULT;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_FAULT: begin
        if (Flush) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // bus address latched at fetch start
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) addr_q <= '0;
    else if (state == S_IDLE && FetchEn && aligned && !hit)
      addr_q <= PC;
  end

  // wait-cycle counter for timeout
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                          cnt_q <= '0;
    else if (state == S_REQ && IMemGnt) cnt_q <= '0;
    else if (state == S_WAIT)           cnt_q <= cnt_q + 8'd1;
  end

  // discard flag: set by flush mid-transaction, cleared entering idle
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      discard_q <= 1'b0;
    else if (state_nx == S_IDLE)
      discard_q <= 1'b0;
    else if (Flush && (state == S_REQ || state == S_WAIT))
      discard_q <= 1'b1;
  end

  // instruction register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      instr_q <= RESET_INSTR;
    else if (state_nx == S_FAULT)
      instr_q <= RESET_INSTR;
    else if (rsp_ok)
      instr_q <= IMemRData;
`ifdef IFETCH_LASTHIT_EN
    else if (state == S_IDLE && state_nx == S_DONE)
      instr_q <= buf_data;
`endif
  end

  assign Instr      = instr_q;
  assign InstrValid = (state == S_DONE) & ~Flush;
  assign FetchStall = FetchEn & (state != S_DONE);
  assign FetchFault = (state == S_FAULT);
  assign IMemReq    = (state == S_REQ);
  assign IMemAddr   = addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Last-hit checks run only when IFETCH_LASTHIT_EN is defined.
module tb_instr_fetch_unit;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        FetchEn;
  logic        Flush;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        FetchStall;
  logic        FetchFault;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic [31:0] IMemRData;
  logic        IMemRValid;
  logic        IMemErr;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch_unit #(
    .RESET_INSTR   (32'h0000_0013),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PC        (PC),
    .FetchEn   (FetchEn),
    .Flush     (Flush),
    .Instr     (Instr),
    .InstrValid(InstrValid),
    .FetchStall(FetchStall),
    .FetchFault(FetchFault),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemGnt   (IMemGnt),
    .IMemRData (IMemRData),
    .IMemRValid(IMemRValid),
    .IMemErr   (IMemErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input int gd,
                       input int rd, input logic [31:0] d);
    PC = pc;
    FetchEn = 1'b1;
    tick;
    for (int i = 0; i < gd; i++) begin
      check("req_hold", 32'(IMemReq), 32'd1);
      check("addr_hold", IMemAddr, pc);
      tick;
    end
    check("req", 32'(IMemReq), 32'd1);
    check("addr", IMemAddr, pc);
    IMemGnt = 1'b1;
    tick;
    IMemGnt = 1'b0;
    for (int i = 1; i < rd; i++) begin
      check("wait_req", 32'(IMemReq), 32'd0);
      check("wait_nv", 32'(InstrValid), 32'd0);
      tick;
    end
    IMemRValid = 1'b1;
    IMemRData  = d;
    tick;
    IMemRValid = 1'b0;
    FetchEn    = 1'b0;
    check("valid", 32'(InstrValid), 32'd1);
    check("instr", Instr, d);
    tick;
    check("valid_1cyc", 32'(InstrValid), 32'd0);
    check("instr_hold", Instr, d);
  endtask

  initial begin
    Reset      = 1'b1;
    PC         = 32'h0;
    FetchEn    = 1'b1;
    Flush      = 1'b0;
    IMemGnt    = 1'b0;
    IMemRData  = 32'h0;
    IMemRValid = 1'b0;
    IMemErr    = 1'b0;
    #1;
    check("rst_instr", Instr, 32'h13);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_req", 32'(IMemReq), 32'd0);
    check("rst_addr", IMemAddr, 32'h0);
    check("rst_fault", 32'(FetchFault), 32'd0);
    check("rst_stall", 32'(FetchStall), 32'd1);
    tick;
    tick;
    check("rst_hold_req", 32'(IMemReq), 32'd0);

    // minimum latency fetch
    Reset = 1'b0;
    PC    = 32'h100;
    check("c0_stall", 32'(FetchStall), 32'd1);
    check("c0_req", 32'(IMemReq), 32'd0);
    tick;
    check("c1_req", 32'(IMemReq), 32'd1);
    check("c1_addr", IMemAddr, 32'h100);
    check("c1_stall", 32'(FetchStall), 32'd1);
    IMemGnt = 1'b1;
    tick;
    IMemGnt    = 1'b0;
    IMemRValid = 1'b1;
    IMemRData  = 32'h0050_0093;
    check("c2_req", 32'(IMemReq), 32'd0);
    check("c2_stall", 32'(FetchStall), 32'd1);
    check("c2_valid", 32'(InstrValid), 32'd0);
    tick;
    IMemRValid = 1'b0;
    check("c3_valid", 32'(InstrValid), 32'd1);
    check("c3_instr", Instr, 32'h0050_0093);
    check("c3_stall", 32'(FetchStall), 32'd0);
    FetchEn = 1'b0;
    tick;
    check("c4_valid", 32'(InstrValid), 32'd0);
    check("c4_instr", Instr, 32'h0050_0093);

    // delayed grant / delayed response
    fetch(32'h104, 3, 1, 32'h00A0_0113);
    fetch(32'h108, 0, 5, 32'h0020_8193);

    // misaligned PC
    PC      = 32'h102;
    FetchEn = 1'b1;
    tick;
    FetchEn = 1'b0;
    check("mis_fault", 32'(FetchFault), 32'd1);
    check("mis_req", 32'(IMemReq), 32'd0);
    check("mis_instr", Instr, 32'h13);
    tick;
    tick;
    check("mis_sticky", 32'(FetchFault), 32'd1);
    check("mis_stall", 32'(FetchStall), 32'd0);
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("mis_clear", 32'(FetchFault), 32'd0);
    check("mis_idle_req", 32'(IMemReq), 32'd0);

    // timeout
    PC      = 32'h300;
    FetchEn = 1'b1;
    tick;
    IMemGnt = 1'b1;
    tick;
    IMemGnt = 1'b0;
    FetchEn = 1'b0;
    check("to_w1", 32'(FetchFault), 32'd0);
    for (int i = 1; i < TO; i++) begin
      tick;
      check("to_wait", 32'(FetchFault), 32'd0);
    end
    tick;
    check("to_fault", 32'(FetchFault), 32'd1);
    check("to_instr", Instr, 32'h13);
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("to_clear", 32'(FetchFault), 32'd0);

    // bus error
    fetch(32'h400, 0, 1, 32'h1234_5678);
    PC      = 32'h404;
    FetchEn = 1'b1;
    tick;
    IMemGnt = 1'b1;
    tick;
    IMemGnt    = 1'b0;
    FetchEn    = 1'b0;
    IMemRValid = 1'b1;
    IMemErr    = 1'b1;
    IMemRData  = 32'hBAD0_BAD0;
    tick;
    IMemRValid = 1'b0;
    IMemErr    = 1'b0;
    check("err_fault", 32'(FetchFault), 32'd1);
    check("err_instr", Instr, 32'h13);
    check("err_valid", 32'(InstrValid), 32'd0);
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("err_clear", 32'(FetchFault), 32'd0);

    // flush in WAIT drops response
    fetch(32'h500, 0, 1, 32'h1111_1111);
    PC      = 32'h504;
    FetchEn = 1'b1;
    tick;
    IMemGnt = 1'b1;
    tick;
    IMemGnt = 1'b0;
    FetchEn = 1'b0;
    Flush   = 1'b1;
    tick;
    Flush      = 1'b0;
    IMemRValid = 1'b1;
    IMemRData  = 32'hDEAD_BEEF;
    tick;
    IMemRValid = 1'b0;
    check("fl_valid", 32'(InstrValid), 32'd0);
    check("fl_instr", Instr, 32'h1111_1111);
    check("fl_req", 32'(IMemReq), 32'd0);
    tick;
    check("fl_valid2", 32'(InstrValid), 32'd0);
    fetch(32'h200, 0, 1, 32'h0030_0213);

    // flush in REQ, errored response dropped without fault
    PC      = 32'h900;
    FetchEn = 1'b1;
    tick;
    IMemGnt = 1'b1;
    Flush   = 1'b1;
    check("flreq_req", 32'(IMemReq), 32'd1);
    tick;
    IMemGnt    = 1'b0;
    Flush      = 1'b0;
    FetchEn    = 1'b0;
    IMemRValid = 1'b1;
    IMemErr    = 1'b1;
    tick;
    IMemRValid = 1'b0;
    IMemErr    = 1'b0;
    check("flerr_fault", 32'(FetchFault), 32'd0);
    check("flerr_valid", 32'(InstrValid), 32'd0);
    check("flerr_instr", Instr, 32'h0030_0213);

    // flush in DONE suppresses valid
    PC      = 32'h700;
    FetchEn = 1'b1;
    tick;
    IMemGnt = 1'b1;
    tick;
    IMemGnt    = 1'b0;
    FetchEn    = 1'b0;
    IMemRValid = 1'b1;
    IMemRData  = 32'h7777_0000;
    tick;
    IMemRValid = 1'b0;
    check("done_valid", 32'(InstrValid), 32'd1);
    Flush = 1'b1;
    #1;
    check("done_flush", 32'(InstrValid), 32'd0);
    tick;
    Flush = 1'b0;
    check("done_after", 32'(InstrValid), 32'd0);

    // reset mid-transaction
    PC      = 32'h800;
    FetchEn = 1'b1;
    tick;
    check("mid_req", 32'(IMemReq), 32'd1);
    Reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(IMemReq), 32'd0);
    check("mid_rst_addr", IMemAddr, 32'h0);
    check("mid_rst_instr", Instr, 32'h13);
    tick;
    Reset   = 1'b0;
    FetchEn = 1'b0;
    tick;

`ifdef IFETCH_LASTHIT_EN
    fetch(32'h100, 0, 1, 32'hABCD_0001);
    PC      = 32'h100;
    FetchEn = 1'b1;
    tick;
    FetchEn = 1'b0;
    check("lh_valid", 32'(InstrValid), 32'd1);
    check("lh_req", 32'(IMemReq), 32'd0);
    check("lh_instr", Instr, 32'hABCD_0001);
    tick;
    PC      = 32'h600;
    FetchEn = 1'b1;
    tick;
    IMemGnt = 1'b1;
    tick;
    IMemGnt    = 1'b0;
    FetchEn    = 1'b0;
    IMemRValid = 1'b1;
    IMemErr    = 1'b1;
    tick;
    IMemRValid = 1'b0;
    IMemErr    = 1'b0;
    Flush      = 1'b1;
    tick;
    Flush = 1'b0;
    fetch(32'h100, 0, 1, 32'hABCD_0002);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
